// File: rtl/lcd_debug_scanner.sv
// Debug-display scanner: snapshots PC + one debug channel per frame and streams hex digits, MSB first.
// Optional LCD_SCAN_ASCII_EN: digits as ASCII hex characters instead of raw nibbles.
module lcd_debug_scanner #(
  parameter int NUM_CH       = 8,
  parameter int DATA_W       = 32,
  parameter int DWELL_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pc,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        sel,
  input  logic                     auto_en,
  input  logic                     freeze,
  input  logic                     start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_row,
  output logic [3:0]               out_pos,
  output logic [7:0]               out_char,
  output logic [3:0]               out_ch,
  output logic                     frame_done
);

  localparam int NDIG = DATA_W / 4;
  localparam int DW   = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [3:0]    LAST_PC    = 4'(NDIG - 1);
  localparam logic [3:0]    LAST_CH    = 4'(NDIG);
  localparam logic [3:0]    ROT_LAST   = 4'(NUM_CH - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SEND_PC, S_SEND_CH, S_DONE} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   pc_q, chd_q;
  logic [3:0]          idx_q, rot_q;
  logic [DW-1:0]       dwell_q;
  logic                auto_q, frz_q;
  logic                out_valid_q, out_row_q, frame_done_q;
  logic [3:0]          out_pos_q;
  logic [7:0]          out_char_q;

  logic [DATA_W-1:0]   cap_pc_d, cap_ch_d;
  logic [3:0]          cap_idx_d, sel_idx;
  logic                sel_any;
  logic [3:0]          next_nib;
  logic [7:0]          next_char_d;

  function automatic logic [3:0] nib(input logic [DATA_W-1:0] v, input logic [3:0] k);
    logic [DATA_W-1:0] s;
    s = v << (4 * k);
    return s[DATA_W-1 -: 4];
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] v);
`ifdef LCD_SCAN_ASCII_EN
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
`else
    return {4'h0, v};
`endif
  endfunction

  // Lowest set bit of sel wins, so scan downwards and let later hits overwrite.
  always_comb begin
    sel_idx = 4'd0;
    sel_any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (sel[k]) begin
        sel_idx = 4'(k);
        sel_any = 1'b1;
      end
    end
    cap_idx_d = auto_en ? rot_q : sel_idx;
    cap_ch_d  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (4'(k) == cap_idx_d) cap_ch_d = ch_data[k*DATA_W +: DATA_W];
    end
    if (!auto_en && !sel_any) cap_ch_d = '0;
    cap_pc_d = pc;
    if (freeze) begin
      cap_idx_d = idx_q;
      cap_ch_d  = chd_q;
      cap_pc_d  = pc_q;
    end
  end

  // Digit to present after the next handshake (or the first digit when leaving CAPTURE).
  always_comb begin
    next_nib = 4'd0;
    case (state_q)
      S_CAPTURE: next_nib = nib(cap_pc_d, 4'd0);
      S_SEND_PC: next_nib = (out_pos_q == LAST_PC) ? idx_q : nib(pc_q, out_pos_q + 4'd1);
      S_SEND_CH: next_nib = nib(chd_q, out_pos_q);
      default:   next_nib = 4'd0;
    endcase
    next_char_d = enc(next_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      chd_q        <= '0;
      idx_q        <= '0;
      rot_q        <= '0;
      dwell_q      <= '0;
      auto_q       <= 1'b0;
      frz_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_row_q    <= 1'b0;
      out_pos_q    <= '0;
      out_char_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_q <= S_CAPTURE;
        S_CAPTURE: begin
          pc_q        <= cap_pc_d;
          chd_q       <= cap_ch_d;
          idx_q       <= cap_idx_d;
          auto_q      <= auto_en;
          frz_q       <= freeze;
          if (!auto_en) dwell_q <= '0;
          out_valid_q <= 1'b1;
          out_row_q   <= 1'b0;
          out_pos_q   <= '0;
          out_char_q  <= next_char_d;
          state_q     <= S_SEND_PC;
        end
        S_SEND_PC: if (out_ready) begin
          out_char_q <= next_char_d;
          if (out_pos_q == LAST_PC) begin
            out_row_q <= 1'b1;
            out_pos_q <= '0;
            state_q   <= S_SEND_CH;
          end else begin
            out_pos_q <= out_pos_q + 4'd1;
          end
        end
        S_SEND_CH: if (out_ready) begin
          if (out_pos_q == LAST_CH) begin
            out_valid_q  <= 1'b0;
            out_row_q    <= 1'b0;
            out_pos_q    <= '0;
            out_char_q   <= '0;
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            out_pos_q  <= out_pos_q + 4'd1;
            out_char_q <= next_char_d;
          end
        end
        S_DONE: begin
          frame_done_q <= 1'b0;
          // Frozen frames repeat old data, so they do not count toward the dwell.
          if (auto_q && !frz_q) begin
            if (dwell_q == DWELL_LAST) begin
              dwell_q <= '0;
              rot_q   <= (rot_q == ROT_LAST) ? 4'd0 : rot_q + 4'd1;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_pos    = out_pos_q;
  assign out_char   = out_char_q;
  assign out_ch     = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_debug_scanner.sv
// Directed bench for lcd_debug_scanner: manual/auto select, backpressure, freeze, mid-frame reset.
module tb_lcd_debug_scanner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  pc;
  logic [255:0] ch_data;
  logic [31:0]  chv [8];
  logic [7:0]   sel;
  logic         auto_en, freeze, start, out_ready;
  logic         out_valid, out_row, frame_done;
  logic [3:0]   out_pos, out_ch;
  logic [7:0]   out_char;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) ch_data[k*32 +: 32] = chv[k];
  end

  lcd_debug_scanner #(.NUM_CH(8), .DATA_W(32), .DWELL_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .ch_data(ch_data), .sel(sel),
    .auto_en(auto_en), .freeze(freeze), .start(start),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_pos(out_pos), .out_char(out_char), .out_ch(out_ch), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] v);
`ifdef LCD_SCAN_ASCII_EN
    string hx = "0123456789ABCDEF";
    return hx[v];
`else
    return {4'h0, v};
`endif
  endfunction

  // Expected {row, pos, char} for digit n of a 17-digit frame.
  function automatic logic [12:0] exp_dig(input int n, input logic [31:0] p,
                                          input logic [31:0] c, input logic [3:0] idx);
    if (n < 8)       return {1'b0, 4'(n), enc(p[31-4*n -: 4])};
    else if (n == 8) return {1'b1, 4'd0, enc(idx)};
    else             return {1'b1, 4'(n-8), enc(c[31-4*(n-9) -: 4])};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] p, input logic [31:0] c,
                           input logic [3:0] idx, input bit tog);
    int w = 0;
    int n = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [12:0] held, cur;
    held = '0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_idx"}, {28'd0, out_ch}, {28'd0, idx});
    while (n < 17 && cyc < 200) begin
      out_ready = tog ? ~out_ready : 1'b1;
      cur = {out_row, out_pos, out_char};
      if (stalled) check({tag, "_stable"}, {19'd0, cur}, {19'd0, held});
      if (out_valid && out_ready) begin
        check($sformatf("%s_d%0d", tag, n), {19'd0, cur}, {19'd0, exp_dig(n, p, c, idx)});
        n++;
        stalled = 1'b0;
      end else begin
        held = cur;
        stalled = out_valid;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_cnt"}, n, 17);
    check({tag, "_done"}, {30'd0, out_valid, frame_done}, 32'b01);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] old_pc, old_ch;
    int w;
    pc = 32'h0040_0010;
    for (int k = 0; k < 8; k++) chv[k] = 32'hC0DE_0000 | (k * 32'h111);
    chv[2] = 32'h1234_ABCD;
    sel = 8'b0000_0100; auto_en = 1'b0; freeze = 1'b0; start = 1'b0; out_ready = 1'b1;

    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_row_pos", {27'd0, out_row, out_pos}, 32'd0);
    check("rst_char", {24'd0, out_char}, 32'd0);
    check("rst_ch_done", {27'd0, out_ch, frame_done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Manual select, first-digit latency and single-cycle frame_done
    pulse_start();
    check("lat_capture", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_first", {31'd0, out_valid}, 32'd1);
    run_frame("man", pc, chv[2], 4'd2, 1'b0);
    @(negedge clk);
    check("done_pulse", {31'd0, frame_done}, 32'd0);

    pulse_start();
    run_frame("bp", pc, chv[2], 4'd2, 1'b1);

    sel = 8'b0;
    pulse_start();
    run_frame("sel0", pc, 32'd0, 4'd0, 1'b0);

    sel = 8'b1010_0000;
    pulse_start();
    run_frame("sel5", pc, chv[5], 4'd5, 1'b0);

    // Auto mode with a frozen frame in between: freeze repeats data and holds the dwell
    auto_en = 1'b1; sel = 8'b0000_0100;
    pulse_start();
    run_frame("a0", pc, chv[0], 4'd0, 1'b0);
    old_pc = pc; old_ch = chv[0];
    freeze = 1'b1; pc = 32'hDEAD_BEEF; chv[0] = 32'h5555_AAAA;
    pulse_start();
    run_frame("frz", old_pc, old_ch, 4'd0, 1'b0);
    freeze = 1'b0;
    pulse_start();
    run_frame("a0b", pc, chv[0], 4'd0, 1'b0);
    pulse_start();
    run_frame("a1", pc, chv[1], 4'd1, 1'b0);

    // Reset in the middle of the channel row
    pulse_start();
    w = 0;
    while (!(out_valid && out_row) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("mid_reached", {31'd0, out_valid & out_row}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_outs", {14'd0, out_row, out_pos, out_char, out_ch, frame_done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    run_frame("post", pc, chv[0], 4'd0, 1'b0);

    // Rotation with start held: two frames per channel, wrapping back to 0
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1;
    for (int f = 0; f < 17; f++) begin
      run_frame($sformatf("rot%0d", f), pc, chv[(f/2)%8], 4'((f/2)%8), 1'b0);
    end
    start = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
